mem_port_arbiter: RTL and testbench

//  Shares the single byte_addressable memory between the instruction-fetch port and the data
//  (load/store) port of the RISC-V core. It arbitrates round-robin when both ports request and

---
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one byte-addressable memory between the fetch port and the
// load/store port; reads wait a fixed latency, writes wait on mem_done with a timeout.
module mem_port_arbiter #(
  parameter int WORD_SIZE     = 32,
  parameter int READ_LATENCY  = 1,
  parameter int WRITE_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [WORD_SIZE-1:0] if_addr,
  output logic                 if_ack,
  output logic [WORD_SIZE-1:0] if_rdata,
  output logic                 if_err,
  input  logic                 d_req,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [1:0]           d_write,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ack,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_err,
  output logic [WORD_SIZE-1:0] mem_address,
  output logic [1:0]           mem_write,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_done,
  input  logic                 mem_error,
  output logic                 busy,
  output logic                 owner
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_READ_WAIT  = 2'd1;
  localparam logic [1:0] ST_WRITE_WAIT = 2'd2;

  logic [1:0] state_reg;
  logic [7:0] cnt_reg;
  logic       last_owner_reg;
  logic       grant_data;

  // On a tie the port that did not own the previous access wins.
  assign grant_data = d_req && (!if_req || !last_owner_reg);
  assign busy       = (state_reg != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= 8'd0;
      last_owner_reg <= 1'b1;
      owner          <= 1'b0;
      if_ack         <= 1'b0;
      if_rdata       <= '0;
      if_err         <= 1'b0;
      d_ack          <= 1'b0;
      d_rdata        <= '0;
      d_err          <= 1'b0;
      mem_address    <= '0;
      mem_write      <= 2'b00;
      mem_wdata      <= '0;
    end else begin
      // Acks and their payloads are single-cycle pulses.
      if_ack   <= 1'b0;
      if_rdata <= '0;
      if_err   <= 1'b0;
      d_ack    <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (if_req || d_req) begin
            owner          <= grant_data;
            last_owner_reg <= grant_data;
            if (grant_data) begin
              mem_address <= d_addr;
              mem_write   <= d_write;
              mem_wdata   <= d_wdata;
              if (d_write != 2'b00) begin
                cnt_reg   <= 8'(WRITE_TIMEOUT);
                state_reg <= ST_WRITE_WAIT;
              end else begin
                cnt_reg   <= 8'(READ_LATENCY);
                state_reg <= ST_READ_WAIT;
              end
            end else begin
              mem_address <= if_addr;
              mem_write   <= 2'b00;
              cnt_reg     <= 8'(READ_LATENCY);
              state_reg   <= ST_READ_WAIT;
            end
          end
        end

        ST_READ_WAIT: begin
          if (cnt_reg == 8'd0) begin
            if (owner) begin
              d_ack   <= 1'b1;
              d_rdata <= mem_error ? '0 : mem_rdata;
              d_err   <= mem_error;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_error ? '0 : mem_rdata;
              if_err   <= mem_error;
            end
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg - 8'd1;
          end
        end

        ST_WRITE_WAIT: begin
          if (mem_error || mem_done || (cnt_reg == 8'd0)) begin
            // mem_error outranks mem_done; an expired counter is a timeout error.
            d_ack     <= 1'b1;
            d_err     <= mem_error || !mem_done;
            mem_write <= 2'b00;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg - 8'd1;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected acks, a monitor pops and checks.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = '0;
  logic [1:0]  d_write = 2'b00;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] mem_address;
  logic [1:0]  mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_done = 1'b0;
  logic        mem_error = 1'b0;
  logic        busy;
  logic        owner;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  mem_port_arbiter #(
    .WORD_SIZE(32), .READ_LATENCY(1), .WRITE_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_addr(d_addr), .d_write(d_write), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_address(mem_address), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_error(mem_error),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h10) return 32'h0050_0093;
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory model: one-cycle registered read.
  always @(posedge clk) mem_rdata <= rom(mem_address);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_ack(input logic p, input logic [31:0] rd, input logic er, input int c);
    exp_t x;
    x.port = p; x.rdata = rd; x.err = er; x.cyc = c;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    chk("dual_ack", {31'b0, if_ack & d_ack}, 32'd0);
    if (!if_ack) begin
      chk("if_rdata_idle", if_rdata, 32'd0);
      chk("if_err_idle", {31'b0, if_err}, 32'd0);
    end
    if (!d_ack) begin
      chk("d_rdata_idle", d_rdata, 32'd0);
      chk("d_err_idle", {31'b0, d_err}, 32'd0);
    end
    if (if_ack || d_ack) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", sb.size(), 32'd1);
      end else begin
        e = sb.pop_front();
        $display("ack port=%0d rdata=%h err=%0b owner=%0d cycle=%0d",
                 d_ack, d_ack ? d_rdata : if_rdata, d_ack ? d_err : if_err, owner, cyc);
        chk("ack_port", {31'b0, d_ack}, {31'b0, e.port});
        chk("ack_owner", {31'b0, owner}, {31'b0, e.port});
        chk("ack_rdata", d_ack ? d_rdata : if_rdata, e.rdata);
        chk("ack_err", {31'b0, d_ack ? d_err : if_err}, {31'b0, e.err});
        chk("ack_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    tick(2);
    // Reset state
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_owner", {31'b0, owner}, 32'd0);
    chk("rst_if_ack", {31'b0, if_ack}, 32'd0);
    chk("rst_d_ack", {31'b0, d_ack}, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_write", {30'b0, mem_write}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);

    // Both ports requesting from reset release: fetch, data, fetch, data
    k = cyc;
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1;  d_addr = 32'h80; d_write = 2'b00;
    expect_ack(1'b0, rom(32'h40), 1'b0, k + 3);
    expect_ack(1'b1, rom(32'h80), 1'b0, k + 6);
    expect_ack(1'b0, rom(32'h40), 1'b0, k + 9);
    expect_ack(1'b1, rom(32'h80), 1'b0, k + 12);
    tick(1);
    chk("rr_owner_first", {31'b0, owner}, 32'd0);
    tick(3);
    chk("rr_owner_second", {31'b0, owner}, 32'd1);
    tick(8);
    if_req = 1'b0; d_req = 1'b0;
    tick(2);

    // Single fetch read
    k = cyc;
    if_req = 1'b1; if_addr = 32'h10;
    expect_ack(1'b0, 32'h0050_0093, 1'b0, k + 3);
    tick(1);
    chk("fetch_busy", {31'b0, busy}, 32'd1);
    chk("fetch_addr", mem_address, 32'h10);
    chk("fetch_mem_write_a", {30'b0, mem_write}, 32'd0);
    tick(1);
    chk("fetch_mem_write_b", {30'b0, mem_write}, 32'd0);
    tick(1);
    if_req = 1'b0;
    tick(2);

    // Data write completed by mem_done; inputs change mid-transaction
    k = cyc;
    d_req = 1'b1; d_write = 2'b11; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
    expect_ack(1'b1, 32'd0, 1'b0, k + 5);
    tick(1);
    chk("wr_mem_write", {30'b0, mem_write}, 32'd3);
    chk("wr_mem_addr", mem_address, 32'h20);
    chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    d_req = 1'b0; d_wdata = 32'h1234_5678; d_addr = 32'h24;
    tick(1);
    chk("wr_wdata_latched", mem_wdata, 32'hDEAD_BEEF);
    tick(2);
    mem_done = 1'b1;
    chk("wr_mem_write_held", {30'b0, mem_write}, 32'd3);
    tick(1);
    mem_done = 1'b0;
    chk("wr_mem_write_drop", {30'b0, mem_write}, 32'd0);
    chk("wr_busy_done", {31'b0, busy}, 32'd0);
    tick(2);

    // Misaligned data read
    k = cyc;
    d_req = 1'b1; d_addr = 32'h22; d_write = 2'b00; mem_error = 1'b1;
    expect_ack(1'b1, 32'd0, 1'b1, k + 3);
    tick(3);
    d_req = 1'b0; mem_error = 1'b0;
    tick(2);

    // Misaligned data write: aborted on the first wait cycle
    k = cyc;
    d_req = 1'b1; d_addr = 32'h22; d_write = 2'b10; d_wdata = 32'hCAFE_F00D; mem_error = 1'b1;
    expect_ack(1'b1, 32'd0, 1'b1, k + 2);
    tick(1);
    chk("werr_mem_write", {30'b0, mem_write}, 32'd2);
    tick(1);
    chk("werr_mem_write_drop", {30'b0, mem_write}, 32'd0);
    d_req = 1'b0; mem_error = 1'b0;
    tick(2);

    // Write timeout with mem_done stuck low
    k = cyc;
    d_req = 1'b1; d_addr = 32'h30; d_write = 2'b01;
    expect_ack(1'b1, 32'd0, 1'b1, k + 6);
    tick(1);
    d_req = 1'b0;
    tick(4);
    chk("to_busy_before", {31'b0, busy}, 32'd1);
    tick(1);
    chk("to_busy_after", {31'b0, busy}, 32'd0);
    chk("to_mem_write", {30'b0, mem_write}, 32'd0);
    tick(2);

    // Reset in the middle of a write
    d_req = 1'b1; d_addr = 32'h44; d_write = 2'b11; d_wdata = 32'h0BAD_F00D;
    tick(2);
    chk("mid_busy", {31'b0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_mem_write", {30'b0, mem_write}, 32'd0);
    chk("mid_rst_mem_address", mem_address, 32'd0);
    chk("mid_rst_mem_wdata", mem_wdata, 32'd0);
    chk("mid_rst_owner", {31'b0, owner}, 32'd0);
    d_req = 1'b0;
    tick(2);
    k = cyc;
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1;  d_addr = 32'h90; d_write = 2'b00;
    expect_ack(1'b0, 32'h0050_0093, 1'b0, k + 3);
    expect_ack(1'b1, rom(32'h90), 1'b0, k + 6);
    tick(6);
    if_req = 1'b0; d_req = 1'b0;
    tick(4);

    chk("sb_drain", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
